// File: rtl/instr_mem_responder.sv
// Memory-side responder for the instruction-fetch req/gnt/valid interface: word RAM, fixed read latency,
// bounded in-order outstanding requests. Define IMEM_RESP_STALL_EN to inject LFSR-driven grant stalls.
module instr_mem_responder #(
  parameter int    DEPTH           = 1024,
  parameter logic [31:0] BASE_ADDR = 32'h0,
  parameter int    LATENCY         = 1,
  parameter int    MAX_OUTSTANDING = 2,
  parameter string INIT_FILE       = ""
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               instr_req,
  input  logic [31:0]                        instr_addr,
  output logic                               instr_gnt,
  output logic [31:0]                        instr_rdata,
  output logic                               instr_err,
  output logic                               instr_valid,
  input  logic                               load_we,
  input  logic [$clog2(DEPTH)-1:0]           load_addr,
  input  logic [31:0]                        load_wdata,
  output logic [$clog2(MAX_OUTSTANDING+1)-1:0] outstanding
);

  localparam int AW = $clog2(DEPTH);
  localparam int OW = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [OW-1:0] MAX_OS = OW'(MAX_OUTSTANDING);

  logic [31:0]        mem [DEPTH];
  logic [32:0]        offset;
  logic [30:0]        word_off;
  logic               unused_byte_sel;
  logic               in_range;
  logic [AW-1:0]      rd_idx;
  logic               retire;
  logic               stall_ok;

  logic [LATENCY-1:0] pipe_v, src_v;
  logic [LATENCY-1:0] pipe_e, src_e;
  logic [31:0]        pipe_d [LATENCY];
  logic [31:0]        src_d  [LATENCY];

  // The borrow bit lands in word_off, so an address below BASE_ADDR reads as a huge offset.
  assign offset          = {1'b0, instr_addr} - {1'b0, BASE_ADDR};
  assign word_off        = offset[32:2];
  assign unused_byte_sel = ^offset[1:0];
  assign in_range        = word_off < 31'(DEPTH);
  assign rd_idx          = word_off[AW-1:0];

  assign retire    = instr_valid;
  assign instr_gnt = instr_req & ~reset & stall_ok & ((outstanding < MAX_OS) | retire);

`ifdef IMEM_RESP_STALL_EN
  logic [7:0] lfsr;

  always_ff @(posedge clk) begin
    if (reset) lfsr <= 8'hA5;
    else       lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
  end

  assign stall_ok = (lfsr[1:0] != 2'b00);
`else
  assign stall_ok = 1'b1;
`endif

  // NOTE: the array is deliberately not reset; a RAM cannot be cleared in one cycle and loads must survive reset.
  always_ff @(posedge clk) begin
    if (load_we) mem[load_addr] <= load_wdata;
  end

  // NOTE: every variable gets a default first so no path leaves it unassigned and infers a latch.
  always_comb begin
    src_v = '0;
    src_e = '0;
    for (int i = 0; i < LATENCY; i++) src_d[i] = '0;
    src_v[0] = instr_gnt;
    src_e[0] = ~in_range;
    src_d[0] = in_range ? mem[rd_idx] : 32'h0;
    for (int i = 1; i < LATENCY; i++) begin
      src_v[i] = pipe_v[i-1];
      src_e[i] = pipe_e[i-1];
      src_d[i] = pipe_d[i-1];
    end
  end

  // NOTE: state uses non-blocking assignments so every stage samples pre-edge values regardless of order.
  always_ff @(posedge clk) begin
    if (reset) begin
      pipe_v <= '0;
      pipe_e <= '0;
      for (int i = 0; i < LATENCY; i++) pipe_d[i] <= '0;
    end else begin
      pipe_v <= src_v;
      // The output stage only captures real beats so rdata/err hold between responses.
      for (int i = 0; i < LATENCY; i++) begin
        if (i != LATENCY - 1 || src_v[i]) begin
          pipe_d[i] <= src_d[i];
          pipe_e[i] <= src_e[i];
        end
      end
    end
  end

  assign instr_valid = pipe_v[LATENCY-1];
  assign instr_rdata = pipe_d[LATENCY-1];
  assign instr_err   = pipe_e[LATENCY-1];

  always_ff @(posedge clk) begin
    if (reset)                      outstanding <= '0;
    else if (instr_gnt && !retire)  outstanding <= outstanding + OW'(1);
    else if (!instr_gnt && retire)  outstanding <= outstanding - OW'(1);
  end

`ifndef SYNTHESIS
  a_valid_has_outstanding: assert property (@(posedge clk) disable iff (reset)
    instr_valid |-> (outstanding != '0));
`endif

endmodule
